microwave_timer_ctrl: RTL and testbench
=======================================

Name: microwave_timer_ctrl

Overview:
- Controller that sequences the microwave's BCD down-counter chain (MM:SS, built from mod10/mod6 counter stages).
- Accepts keypad digits into a shift register and loads them into the chain.
- Gates the count enable from the start, stop/clear and door inputs, and reports completion.
- Sits between the keypad/button front end and the timer counter chain; the chain's outputs go to the display.

Parameters:
- DIGITS, 4, number of BCD digits entered and loaded.
- QUICK_START, 16'h0030, BCD value loaded when start is pressed with no digits entered (30 s).
- DONE_CYCLES, 8, clock cycles that done stays high before returning to IDLE; must be ≥1.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous active-high reset.
- key_valid  in  1  one-cycle strobe: key_digit is valid.
- key_digit  in  4  BCD digit from keypad.
- start  in  1  one-cycle start/resume strobe.
- stop_clear  in  1  one-cycle stop/clear strobe.
- door_closed  in  1  level, 1 = door closed.
- timer_zero  in  1  level from counter chain, 1 = all digits zero.
- load_value  out  4*DIGITS  BCD value driven to the chain's input_number ports; digit 0 is in the LSBs.
- count_loadn  out  1  active-low load strobe to the chain.
- count_clearn  out  1  active-low synchronous clear strobe to the chain.
- count_enable  out  1  count-down enable to the chain.
- magnetron_on  out  1  heating active.
- done  out  1  cook-complete indication.
- state  out  3  current state code, for debug and display.

Behaviour:
- States (codes): IDLE=0, ENTRY=1, LOAD=2, RUNNING=3, PAUSED=4, DONE=5.
- All outputs are registered.
- Reset (clear=1, asynchronous):
  - state=IDLE, entry register=0, load_value=0.
  - count_loadn=1, count_clearn=1, count_enable=0, magnetron_on=0, done=0.
  - Reset mid-RUNNING stops counting immediately (async); the chain keeps its value until cleared.
- Digit entry:
  - Applies only in IDLE or ENTRY; key_valid with key_digit ≤ 9 does entry = {entry[lower DIGITS-1 digits], key_digit}.
  - Digits shifted past the top are discarded.
  - key_digit > 9 is ignored.
  - Any accepted digit moves IDLE to ENTRY.
  - key_valid in any other state is ignored.
  - load_value always mirrors the entry register.
- Input priority per cycle: stop_clear > door_closed=0 > start > timer_zero > key_valid.
- IDLE:
  - start with door_closed=1: entry ← QUICK_START, go to LOAD.
  - start with the door open: ignored.
  - stop_clear: count_clearn=0 for one cycle, stay IDLE.
- ENTRY:
  - start with door_closed=1 and entry ≠ 0: go to LOAD.
  - start with entry = 0: ignored, stay ENTRY.
  - stop_clear: entry ← 0, go to IDLE.
- LOAD: exactly one cycle; count_loadn=0 and count_enable=0; next state is RUNNING.
- RUNNING:
  - count_enable=1, magnetron_on=1; both fall in the same cycle the state is left.
  - stop_clear or door_closed=0: go to PAUSED.
  - timer_zero=1, sampled from the cycle after entering RUNNING: go to DONE.
  - Simultaneous door open and timer_zero: PAUSED wins.
- PAUSED:
  - count_enable=0, magnetron_on=0; the chain holds its value.
  - start with door_closed=1: RUNNING, no reload.
  - stop_clear: count_clearn=0 for one cycle, entry ← 0, go to IDLE.
  - start and stop_clear together: stop_clear wins.
- DONE:
  - done=1 and count_enable=0 for DONE_CYCLES cycles, then IDLE with entry ← 0.
  - stop_clear cuts it short: IDLE on the next edge.
  - start and key_valid are ignored.
- Strobe rule: count_loadn and count_clearn are never low in the same cycle, and never low for more than one consecutive cycle.
- Output latency: every output reflects the state entered at the edge on which that state is registered.

Test Plan:
- Entry and load: after reset, keys 1,2,3,4 then start, door closed → load_value=16'h1234. count_loadn=0 for exactly one cycle, then count_enable=1 and magnetron_on=1.
- Overflow and invalid digits:
  - Keys 1,2,3,4,5 → load_value=16'h2345.
  - key_digit=4'hA → load_value unchanged.
- Quick start and zero entry:
  - Start in IDLE → load_value=16'h0030, LOAD then RUNNING.
  - Keys 0,0 then start → stays ENTRY, count_loadn stays 1.
- Door pause and resume: in RUNNING, door_closed=0 → PAUSED with count_enable=0 next edge. Start while the door is open is ignored. Door closed then start → RUNNING, no count_loadn pulse.
- Completion: in RUNNING, assert timer_zero → DONE, done=1 for 8 cycles, then IDLE with entry=0. A start during DONE has no effect.
- Clear and reset:
  - PAUSED plus simultaneous start and stop_clear → count_clearn=0 one cycle, then IDLE.
  - Async clear mid-RUNNING → all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer sequencer: keypad digit entry, load/clear strobes and
// count gating for the external BCD MM:SS down-counter chain.
module microwave_timer_ctrl #(
  parameter int unsigned             DIGITS      = 4,
  parameter logic [4*DIGITS-1:0]     QUICK_START = 16'h0030,
  parameter int unsigned             DONE_CYCLES = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  key_valid,
  input  logic [3:0]            key_digit,
  input  logic                  start,
  input  logic                  stop_clear,
  input  logic                  door_closed,
  input  logic                  timer_zero,
  output logic [4*DIGITS-1:0]   load_value,
  output logic                  count_loadn,
  output logic                  count_clearn,
  output logic                  count_enable,
  output logic                  magnetron_on,
  output logic                  done,
  output logic [2:0]            state
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    LOAD    = 3'd2,
    RUNNING = 3'd3,
    PAUSED  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t          cur, nxt;
  logic [W-1:0]    entry_nxt;
  logic [W-1:0]    entry_shift;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            clear_req;
  logic            digit_ok;
  logic            loadn_nxt, clearn_nxt, enable_nxt, done_nxt;

  // load_value is the entry register itself; new digit enters at the LSBs
  assign entry_shift = W'({load_value, key_digit});
  assign digit_ok    = key_valid && (key_digit <= 4'd9);
  assign state       = cur;

  always_comb begin
    nxt       = cur;
    entry_nxt = load_value;
    cnt_nxt   = cnt;
    clear_req = 1'b0;
    case (cur)
      IDLE: begin
        if (stop_clear) begin
          clear_req = 1'b1;
        end else if (start && door_closed) begin
          entry_nxt = QUICK_START;
          nxt       = LOAD;
        end else if (digit_ok) begin
          entry_nxt = entry_shift;
          nxt       = ENTRY;
        end
      end
      ENTRY: begin
        if (stop_clear) begin
          entry_nxt = '0;
          nxt       = IDLE;
        end else if (start && door_closed && (load_value != '0)) begin
          nxt = LOAD;
        end else if (digit_ok) begin
          entry_nxt = entry_shift;
        end
      end
      LOAD: nxt = RUNNING;
      RUNNING: begin
        if (stop_clear || !door_closed) begin
          nxt = PAUSED;
        end else if (timer_zero) begin
          nxt     = DONE;
          cnt_nxt = '0;
        end
      end
      PAUSED: begin
        if (stop_clear) begin
          clear_req = 1'b1;
          entry_nxt = '0;
          nxt       = IDLE;
        end else if (start && door_closed) begin
          nxt = RUNNING;
        end
      end
      DONE: begin
        if (stop_clear || (cnt == DONE_LAST)) begin
          entry_nxt = '0;
          nxt       = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it.
    // A held stop_clear must not stretch the clear strobe past one cycle.
    loadn_nxt  = (nxt != LOAD);
    clearn_nxt = !(clear_req && count_clearn);
    enable_nxt = (nxt == RUNNING);
    done_nxt   = (nxt == DONE);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cur          <= IDLE;
      load_value   <= '0;
      cnt          <= '0;
      count_loadn  <= 1'b1;
      count_clearn <= 1'b1;
      count_enable <= 1'b0;
      magnetron_on <= 1'b0;
      done         <= 1'b0;
    end else begin
      cur          <= nxt;
      load_value   <= entry_nxt;
      cnt          <= cnt_nxt;
      count_loadn  <= loadn_nxt;
      count_clearn <= clearn_nxt;
      count_enable <= enable_nxt;
      magnetron_on <= enable_nxt;
      done         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios plus random stimulus,
// all checked cycle by cycle against a digit-list reference model.
module tb_microwave_timer_ctrl;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned DONE_CYCLES = 8;
  localparam logic [15:0] QS          = 16'h0030;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2, M_RUN = 3, M_PAUSE = 4, M_DONE = 5;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        start = 1'b0;
  logic        stop_clear = 1'b0;
  logic        door_closed = 1'b1;
  logic        timer_zero = 1'b0;
  logic [15:0] load_value;
  logic        count_loadn, count_clearn, count_enable, magnetron_on, done;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: a list of decimal digits plus a mode number
  int m_mode;
  int m_dig[DIGITS];
  int m_done_left;
  bit m_clearn;

  microwave_timer_ctrl #(
    .DIGITS      (DIGITS),
    .QUICK_START (QS),
    .DONE_CYCLES (DONE_CYCLES)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .start        (start),
    .stop_clear   (stop_clear),
    .door_closed  (door_closed),
    .timer_zero   (timer_zero),
    .load_value   (load_value),
    .count_loadn  (count_loadn),
    .count_clearn (count_clearn),
    .count_enable (count_enable),
    .magnetron_on (magnetron_on),
    .done         (done),
    .state        (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int m_value();
    int v = 0;
    for (int i = 0; i < DIGITS; i++) v += m_dig[i] * (1 << (4 * i));
    return v;
  endfunction

  task automatic m_zero();
    for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
  endtask

  task automatic m_reset();
    m_mode = M_IDLE;
    m_zero();
    m_done_left = 0;
    m_clearn = 1'b1;
  endtask

  task automatic m_push(input int d);
    for (int i = DIGITS - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
    m_dig[0] = d;
  endtask

  task automatic m_step();
    bit want_clear = 1'b0;
    bit key_ok = key_valid && (key_digit <= 9);
    bit go = start && door_closed;
    case (m_mode)
      M_IDLE:
        if (stop_clear) want_clear = 1'b1;
        else if (go) begin
          for (int i = 0; i < DIGITS; i++) m_dig[i] = (int'(QS) >> (4 * i)) % 16;
          m_mode = M_LOAD;
        end else if (key_ok) begin
          m_push(int'(key_digit));
          m_mode = M_ENTRY;
        end
      M_ENTRY:
        if (stop_clear) begin m_zero(); m_mode = M_IDLE; end
        else if (go && m_value() != 0) m_mode = M_LOAD;
        else if (key_ok) m_push(int'(key_digit));
      M_LOAD: m_mode = M_RUN;
      M_RUN:
        if (stop_clear || !door_closed) m_mode = M_PAUSE;
        else if (timer_zero) begin m_mode = M_DONE; m_done_left = DONE_CYCLES; end
      M_PAUSE:
        if (stop_clear) begin want_clear = 1'b1; m_zero(); m_mode = M_IDLE; end
        else if (go) m_mode = M_RUN;
      default: begin
        m_done_left--;
        if (stop_clear || m_done_left == 0) begin m_zero(); m_mode = M_IDLE; end
      end
    endcase
    m_clearn = !(want_clear && m_clearn);
  endtask

  task automatic check_all();
    check("state",     32'(state),        32'(m_mode));
    check("load_value",32'(load_value),   32'(m_value()));
    check("loadn",     32'(count_loadn),  32'(m_mode != M_LOAD));
    check("clearn",    32'(count_clearn), 32'(m_clearn));
    check("enable",    32'(count_enable), 32'(m_mode == M_RUN));
    check("magnetron", 32'(magnetron_on), 32'(m_mode == M_RUN));
    check("done",      32'(done),         32'(m_mode == M_DONE));
  endtask

  // one clock: inputs already set, model advances on the edge, compare 1 time unit later
  task automatic cycle();
    @(posedge clock);
    m_step();
    #1;
    check_all();
    key_valid  = 1'b0;
    start      = 1'b0;
    stop_clear = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    cycle();
  endtask

  task automatic press_start();
    start = 1'b1;
    cycle();
  endtask

  task automatic do_reset();
    #2 clear = 1'b1;
    m_reset();
    #1 check_all();
    @(posedge clock);
    #1 clear = 1'b0;
    door_closed = 1'b1;
    timer_zero  = 1'b0;
  endtask

  initial begin
    int n;
    m_reset();
    #12;
    check_all();
    check("reset_state", 32'(state), 32'(M_IDLE));
    @(posedge clock);
    #1 clear = 1'b0;

    // entry and load
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    check("entry_1234", 32'(load_value), 32'h1234);
    press_start();
    check("load_strobe", 32'(count_loadn), 32'd0);
    cycle();
    check("load_one_cycle", 32'(count_loadn), 32'd1);
    check("run_enable", 32'(count_enable), 32'd1);

    // overflow and invalid digits
    do_reset();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    check("overflow", 32'(load_value), 32'h2345);
    key(4'hA);
    check("invalid_digit", 32'(load_value), 32'h2345);

    // quick start
    do_reset();
    press_start();
    check("quick_value", 32'(load_value), 32'h0030);
    check("quick_load", 32'(state), 32'(M_LOAD));
    cycle();
    check("quick_run", 32'(state), 32'(M_RUN));

    // zero entry: start refused
    do_reset();
    key(4'd0); key(4'd0);
    press_start();
    check("zero_stay", 32'(state), 32'(M_ENTRY));
    check("zero_noload", 32'(count_loadn), 32'd1);

    // door pause and resume
    do_reset();
    press_start(); cycle();
    door_closed = 1'b0; cycle();
    check("door_pause", 32'(state), 32'(M_PAUSE));
    check("door_noenable", 32'(count_enable), 32'd0);
    press_start();
    check("door_open_start", 32'(state), 32'(M_PAUSE));
    door_closed = 1'b1; cycle();
    press_start();
    check("resume", 32'(state), 32'(M_RUN));
    check("resume_noload", 32'(count_loadn), 32'd1);

    // completion, with a start during DONE
    timer_zero = 1'b1; cycle();
    timer_zero = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && done; i++) begin
      n++;
      if (i == 2) start = 1'b1;
      cycle();
    end
    check("done_len", 32'(n), 32'(DONE_CYCLES));
    check("done_idle", 32'(state), 32'(M_IDLE));
    check("done_entry0", 32'(load_value), 32'd0);

    // paused + start + stop_clear together
    press_start(); cycle();
    stop_clear = 1'b1; cycle();
    start = 1'b1; stop_clear = 1'b1; cycle();
    check("pclear_strobe", 32'(count_clearn), 32'd0);
    check("pclear_idle", 32'(state), 32'(M_IDLE));
    cycle();
    check("pclear_one", 32'(count_clearn), 32'd1);

    // async clear mid-run
    press_start(); cycle();
    #3 clear = 1'b1;
    #1;
    check("async_enable", 32'(count_enable), 32'd0);
    check("async_magnetron", 32'(magnetron_on), 32'd0);
    check("async_state", 32'(state), 32'(M_IDLE));
    check("async_value", 32'(load_value), 32'd0);
    m_reset();
    @(posedge clock);
    #1 clear = 1'b0;

    // random stimulus
    for (int c = 0; c < 4000; c++) begin
      key_valid  = ($urandom_range(0, 99) < 30);
      key_digit  = 4'($urandom_range(0, 15));
      start      = ($urandom_range(0, 99) < 12);
      stop_clear = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 4) door_closed = ~door_closed;
      timer_zero = ($urandom_range(0, 99) < 6);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
